// File: rtl/mul_add_binary_pkg.sv
// Shared constants and types for the shift-add multiply-accumulate (a = q*b + r).
// Holds the default operand width, the FSM state encoding and the step-counter width helper.
package mul_add_binary_pkg;

  localparam int WIDTH_DEFAULT = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter holds step indices 0..w-1; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/mul_add_binary.sv
// Sequential shift-add multiply-accumulate: rebuilds a = q*b + r in exactly WIDTH RUN cycles.
// Handshake: start is a one-cycle request accepted in IDLE or DONE; ready_n=0 marks a fresh a/overflow.
module mul_add_binary
  import mul_add_binary_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] a,
  output logic             overflow,
  output logic             ready_n,
  output state_t           state
);

  localparam int CW = cnt_width(WIDTH);

  state_t             state_nxt;
  logic               load;
  logic               step;
  logic               finish;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_sum;
  logic [WIDTH-1:0]   mplr;
  logic [CW-1:0]      cnt;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The 2*WIDTH accumulator cannot overflow: max is 2^(2W) - 2^W.
  assign acc_sum = mplr[0] ? (acc + mcand) : acc;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand    <= '0;
      acc      <= '0;
      mplr     <= '0;
      cnt      <= '0;
      a        <= '0;
      overflow <= 1'b0;
      ready_n  <= 1'b1;
    end else if (load) begin
      mcand   <= {{WIDTH{1'b0}}, b};
      acc     <= {{WIDTH{1'b0}}, r};
      mplr    <= q;
      cnt     <= '0;
      ready_n <= 1'b1;
    end else if (step) begin
      acc   <= acc_sum;
      mcand <= mcand << 1;
      mplr  <= mplr >> 1;
      cnt   <= cnt + CW'(1);
      if (finish) begin
        a        <= acc_sum[WIDTH-1:0];
        overflow <= |acc_sum[2*WIDTH-1:WIDTH];
        ready_n  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mul_add_binary.sv
// Directed plus randomized bench for mul_add_binary against a 128-bit arithmetic model of q*b + r.
// Covers latency, hold-in-DONE, divider round-trips, overflow corners, start-in-RUN, reset abort and back-to-back.
module tb_mul_add_binary;
  import mul_add_binary_pkg::*;

  localparam int W = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  q = '0;
  logic [W-1:0]  b = '0;
  logic [W-1:0]  r = '0;
  logic [W-1:0]  a;
  logic          overflow;
  logic          ready_n;
  state_t        state;

  int vectors = 0;
  int miscompares = 0;

  mul_add_binary #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .q(q), .b(b), .r(r),
    .a(a), .overflow(overflow), .ready_n(ready_n), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: full-precision product plus addend, split into result and overflow.
  task automatic model(input logic [W-1:0] mq, input logic [W-1:0] mb, input logic [W-1:0] mr,
                       output logic [W-1:0] ea, output logic eov);
    logic [127:0] full;
    full = 128'(mq) * 128'(mb) + 128'(mr);
    ea  = full[W-1:0];
    eov = (full >= (128'd1 << W));
  endtask

  task automatic do_start(input logic [W-1:0] sq, input logic [W-1:0] sb, input logic [W-1:0] sr);
    @(negedge clk);
    q = sq; b = sb; r = sr; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (ready_n !== 1'b0 && cyc < 200) begin
      @(posedge clk);
      #1 cyc++;
    end
  endtask

  task automatic run_check(input string tag, input logic [W-1:0] sq, input logic [W-1:0] sb,
                           input logic [W-1:0] sr);
    int cyc;
    logic [W-1:0] ea;
    logic eov;
    model(sq, sb, sr, ea, eov);
    do_start(sq, sb, sr);
    wait_done(cyc);
    check({tag, "_latency"}, 128'(cyc), 128'd64);
    check({tag, "_a"}, 128'(a), 128'(ea));
    check({tag, "_ovf"}, 128'(overflow), 128'(eov));
  endtask

  initial begin
    int cyc;
    logic [W-1:0] ea;
    logic eov;
    logic [W-1:0] prev_a;
    int dividend;
    int divisor;

    // Reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_a", 128'(a), 128'd0);
    check("reset_ovf", 128'(overflow), 128'd0);
    check("reset_ready_n", 128'(ready_n), 128'd1);
    check("reset_state", 128'(state), 128'(IDLE));

    // q=0: fixed latency, no early termination
    run_check("q_zero", 64'd0, 64'd12345, 64'd5);
    check("q_zero_const", 128'(a), 128'd5);

    run_check("basic", 64'd123, 64'd4567, 64'd89);
    check("basic_const", 128'(a), 128'd561830);
    prev_a = a;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check("hold_a", 128'(a), 128'(prev_a));
      check("hold_ready_n", 128'(ready_n), 128'd0);
    end

    // Divider round-trips
    run_check("div_rt", 64'd20, 64'd4999, 64'd4998);
    check("div_rt_const", 128'(a), 128'd104978);
    for (int i = 0; i < 5; i++) begin
      dividend = int'($urandom_range(0, 99999));
      divisor  = int'($urandom_range(1, 5000));
      run_check("div_rand", 64'(dividend / divisor), 64'(divisor), 64'(dividend % divisor));
      check("div_rand_dividend", 128'(a), 128'(dividend));
    end

    // Overflow corners
    run_check("ovf_pow", 64'h8000_0000_0000_0000, 64'd2, 64'd0);
    run_check("ovf_max", {W{1'b1}}, {W{1'b1}}, {W{1'b1}});
    run_check("ovf_carry", 64'd1, {W{1'b1}}, 64'd1);

    // Random full-width operands
    for (int i = 0; i < 8; i++) begin
      run_check("rand", {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
    end

    // start during RUN is ignored; a does not move while running
    prev_a = a;
    model(64'd777, 64'd999, 64'd3, ea, eov);
    do_start(64'd777, 64'd999, 64'd3);
    repeat (9) @(posedge clk);
    #1 q = 64'd5; b = 64'd6; r = 64'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("run_start_ready_n", 128'(ready_n), 128'd1);
    check("run_hold_a", 128'(a), 128'(prev_a));
    wait_done(cyc);
    check("run_start_latency", 128'(cyc + 10), 128'd64);
    check("run_start_a", 128'(a), 128'(ea));
    check("run_start_ovf", 128'(overflow), 128'(eov));

    // Reset mid-run aborts
    do_start(64'd31, 64'd41, 64'd59);
    repeat (29) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("abort_a", 128'(a), 128'd0);
    check("abort_ovf", 128'(overflow), 128'd0);
    check("abort_ready_n", 128'(ready_n), 128'd1);
    check("abort_state", 128'(state), 128'(IDLE));
    run_check("after_abort", 64'd31, 64'd41, 64'd59);

    // Back-to-back start from DONE with new operands
    model(64'd1000003, 64'd999983, 64'd17, ea, eov);
    do_start(64'd1000003, 64'd999983, 64'd17);
    check("b2b_ready_n", 128'(ready_n), 128'd1);
    check("b2b_state", 128'(state), 128'(RUN));
    wait_done(cyc);
    check("b2b_latency", 128'(cyc), 128'd64);
    check("b2b_a", 128'(a), 128'(ea));

    // rst and start together: reset wins, no operation starts
    @(negedge clk);
    rst = 1'b1; start = 1'b1; q = 64'd9; b = 64'd9; r = 64'd9;
    @(posedge clk);
    #1 rst = 1'b0; start = 1'b0;
    check("rst_win_state", 128'(state), 128'(IDLE));
    check("rst_win_ready_n", 128'(ready_n), 128'd1);
    check("rst_win_a", 128'(a), 128'd0);
    repeat (70) @(posedge clk);
    #1;
    check("rst_win_idle_ready_n", 128'(ready_n), 128'd1);
    check("rst_win_idle_state", 128'(state), 128'(IDLE));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
